entity_mover: RTL and testbench

ENTITY_MOVER -- requirements
Module: entity_mover

---
 rtl/pacman_pkg.sv | 45 ++++
 rtl/frame_edge.sv | 33 +++
 rtl/entity_mover.sv | 145 ++++++++++++++
 tb/tb_entity_mover.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared types and constants for the maze entity movers.
// Holds the horizontal step helper used with or without tunnel wrap.
package pacman_pkg;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    LEFT  = 2'b01,
    DOWN  = 2'b10,
    RIGHT = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    StIdle,
    StChkReq,
    StChkCur,
    StStep
  } mover_state_e;

  localparam int unsigned TILE_PX   = 8;
  localparam int unsigned MAZE_W_PX = 224;

  // Horizontal step of spd pixels; saturates at the maze edges unless wrap is set.
  function automatic logic [9:0] step_x(input logic [9:0] x, input logic [1:0] spd,
                                        input logic right, input logic wrap);
    logic [10:0] sum;
    logic [9:0]  res;
    sum = '0;
    if (right) begin
      sum = {1'b0, x} + {9'd0, spd};
      if (sum >= 11'(MAZE_W_PX)) begin
        res = wrap ? 10'(sum - 11'(MAZE_W_PX)) : 10'(MAZE_W_PX - 1);
      end else begin
        res = sum[9:0];
      end
    end else begin
      if (x < {8'd0, spd}) begin
        res = wrap ? 10'(MAZE_W_PX) - ({8'd0, spd} - x) : 10'd0;
      end else begin
        res = x - {8'd0, spd};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/frame_edge.sv
// Synchronises the raw frame clock into the system domain and emits a
// one-cycle tick on each rising edge.
module frame_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic frame_clk_i,
  output logic tick_o
);

  logic sync1_q, sync2_q, prev_q;
  logic sync1_d, sync2_d, prev_d;

  always_comb begin
    sync1_d = frame_clk_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign tick_o = sync2_q & ~prev_q;

endmodule

// File: rtl/entity_mover.sv
// Moves one maze entity a step per frame tick after consulting the wall checker.
// Define TUNNEL_WRAP_EN to wrap X through the side tunnel instead of saturating.
module entity_mover
  import pacman_pkg::*;
#(
  parameter logic [2:0] ENTITY    = 3'd1,
  parameter logic [9:0] START_X   = 10'd116,
  parameter logic [9:0] START_Y   = 10'd188,
  parameter logic [1:0] START_DIR = 2'b01,
  parameter logic [1:0] SPEED     = 2'd1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       req_valid,
  input  logic [1:0] req_dir,
  input  logic       allowed,
  output logic [2:0] query_entity,
  output logic [9:0] query_x,
  output logic [9:0] query_y,
  output logic [1:0] query_dir,
  output logic [9:0] posX,
  output logic [9:0] posY,
  output logic [1:0] cur_dir,
  output logic       moving,
  output logic       step_done,
  output logic       overrun
);

`ifdef TUNNEL_WRAP_EN
  localparam logic WrapEn = 1'b1;
`else
  localparam logic WrapEn = 1'b0;
`endif

  logic tick;

  frame_edge u_frame_edge (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .frame_clk_i (frame_clk),
    .tick_o      (tick)
  );

  mover_state_e state_q, state_d;
  logic [9:0]   pos_x_q, pos_x_d;
  logic [9:0]   pos_y_q, pos_y_d;
  dir_t         cur_dir_q, cur_dir_d;
  dir_t         pend_dir_q, pend_dir_d;
  logic         pending_q, pending_d;
  logic         moving_q, moving_d;
  logic         step_done_q, step_done_d;
  logic         overrun_q, overrun_d;
  dir_t         query_dir_c;

  always_comb begin
    state_d     = state_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    cur_dir_d   = cur_dir_q;
    moving_d    = moving_q;
    step_done_d = 1'b0;
    overrun_d   = tick && (state_q != StIdle);
    query_dir_c = cur_dir_q;
    // A fresh strobe always lands in the pending slot, even while one is being accepted.
    pend_dir_d  = req_valid ? dir_t'(req_dir) : pend_dir_q;
    pending_d   = pending_q | req_valid;

    unique case (state_q)
      StIdle: begin
        if (tick) begin
          state_d = pending_q ? StChkReq : StChkCur;
        end
      end
      StChkReq: begin
        query_dir_c = pend_dir_q;
        if (allowed) begin
          cur_dir_d = pend_dir_q;
          pending_d = req_valid;
          moving_d  = 1'b1;
          state_d   = StStep;
        end else begin
          state_d = StChkCur;
        end
      end
      StChkCur: begin
        if (allowed) begin
          moving_d = 1'b1;
          state_d  = StStep;
        end else begin
          moving_d = 1'b0;
          state_d  = StIdle;
        end
      end
      StStep: begin
        unique case (cur_dir_q)
          UP:    pos_y_d = pos_y_q - {8'd0, SPEED};
          DOWN:  pos_y_d = pos_y_q + {8'd0, SPEED};
          LEFT:  pos_x_d = step_x(pos_x_q, SPEED, 1'b0, WrapEn);
          RIGHT: pos_x_d = step_x(pos_x_q, SPEED, 1'b1, WrapEn);
          default: ;
        endcase
        step_done_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      pos_x_q     <= START_X;
      pos_y_q     <= START_Y;
      cur_dir_q   <= dir_t'(START_DIR);
      pend_dir_q  <= UP;
      pending_q   <= 1'b0;
      moving_q    <= 1'b0;
      step_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      cur_dir_q   <= cur_dir_d;
      pend_dir_q  <= pend_dir_d;
      pending_q   <= pending_d;
      moving_q    <= moving_d;
      step_done_q <= step_done_d;
      overrun_q   <= overrun_d;
    end
  end

  assign query_entity = ENTITY;
  assign query_x      = pos_x_q;
  assign query_y      = pos_y_q;
  assign query_dir    = query_dir_c;
  assign posX         = pos_x_q;
  assign posY         = pos_y_q;
  assign cur_dir      = cur_dir_q;
  assign moving       = moving_q;
  assign step_done    = step_done_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_entity_mover.sv
// Self-checking bench for entity_mover: directed vector table, corner sequences,
// and randomised ticks against a tick-level behavioural model.
module tb_entity_mover;

  localparam int SPD = 1;
`ifdef TUNNEL_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_dir = 2'b00;
  logic       allowed;
  logic [2:0] query_entity;
  logic [9:0] query_x, query_y, posX, posY;
  logic [1:0] query_dir, cur_dir;
  logic       moving, step_done, overrun;

  int allow_mode = 0;
  int n_cmp = 0;
  int n_bad = 0;

  entity_mover dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .req_valid    (req_valid),
    .req_dir      (req_dir),
    .allowed      (allowed),
    .query_entity (query_entity),
    .query_x      (query_x),
    .query_y      (query_y),
    .query_dir    (query_dir),
    .posX         (posX),
    .posY         (posY),
    .cur_dir      (cur_dir),
    .moving       (moving),
    .step_done    (step_done),
    .overrun      (overrun)
  );

  always #5 Clk = ~Clk;

  // Maze environment: 0 all walls, 1 open, 2 only UP blocked, 3 pseudo-random maze.
  function automatic bit wall_ok(input int mode, input int x, input int y, input int d);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return d != 0;
      default: return ((x + 2 * y + 3 * d) % 5) != 0;
    endcase
  endfunction

  always_comb allowed = wall_ok(allow_mode, int'(query_x), int'(query_y), int'(query_dir));

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model state
  int mx, my, mdir, mpend, mpdir, mmov;

  task automatic model_init();
    mx = 116; my = 188; mdir = 1; mpend = 0; mpdir = 0; mmov = 0;
  endtask

  task automatic model_move(input int d);
    case (d)
      0: my = (my - SPD + 1024) % 1024;
      2: my = (my + SPD) % 1024;
      1: mx = (mx - SPD < 0) ? (WRAP ? mx - SPD + 224 : 0) : mx - SPD;
      default: mx = (mx + SPD > 223) ? (WRAP ? mx + SPD - 224 : 223) : mx + SPD;
    endcase
  endtask

  // Edge index (after frame_clk rises) at which the step should appear, 0 if none.
  task automatic model_tick(input bit rq, input int rd, input int mode, output int lat);
    if (rq) begin
      mpend = 1; mpdir = rd;
    end
    lat = 0;
    if (mpend != 0 && wall_ok(mode, mx, my, mpdir)) begin
      mdir = mpdir; mpend = 0; model_move(mdir); mmov = 1; lat = 5;
    end else if (wall_ok(mode, mx, my, mdir)) begin
      lat = (mpend != 0) ? 6 : 5;
      model_move(mdir); mmov = 1;
    end else begin
      mmov = 0;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; frame_clk = 1'b0; req_valid = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    model_init();
  endtask

  task automatic do_tick(input bit rq, input logic [1:0] rd, input int mode, input bit late,
                         input logic [1:0] ld, output int lat, output int nsd, output int nov);
    allow_mode = mode;
    lat = 0; nsd = 0; nov = 0;
    if (rq) begin
      @(negedge Clk); req_valid = 1'b1; req_dir = rd;
      @(negedge Clk); req_valid = 1'b0;
    end
    @(negedge Clk);
    frame_clk = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge Clk);
      #1;
      if (step_done) begin
        nsd++;
        if (lat == 0) lat = k;
      end
      if (overrun) nov++;
      if (k == 3) begin
        frame_clk = 1'b0;
        if (late) begin
          req_valid = 1'b1; req_dir = ld;
        end
      end
      if (k == 4) req_valid = 1'b0;
    end
  endtask

  task automatic check_model(input string tag, input int lat, input int nsd, input int nov,
                             input int elat);
    check({tag, ".posX"}, int'(posX), mx);
    check({tag, ".posY"}, int'(posY), my);
    check({tag, ".cur_dir"}, int'(cur_dir), mdir);
    check({tag, ".moving"}, int'(moving), mmov);
    check({tag, ".latency"}, lat, elat);
    check({tag, ".steps"}, nsd, (elat != 0) ? 1 : 0);
    check({tag, ".overrun"}, nov, 0);
  endtask

  task automatic run_model(input string tag, input bit rq, input int rd, input int mode);
    int elat, lat, nsd, nov;
    model_tick(rq, rd, mode, elat);
    do_tick(rq, 2'(rd), mode, 1'b0, 2'b00, lat, nsd, nov);
    check_model(tag, lat, nsd, nov, elat);
  endtask

  typedef struct {
    bit         rq;
    logic [1:0] rd;
    int         mode;
    int         x, y, d, mov, lat;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int lat, nsd, nov, guard;

    tbl[0] = '{1'b0, 2'd0, 1, 115, 188, 1, 1, 5};
    tbl[1] = '{1'b1, 2'd0, 2, 114, 188, 1, 1, 6};
    tbl[2] = '{1'b0, 2'd0, 1, 114, 187, 0, 1, 5};
    tbl[3] = '{1'b0, 2'd0, 0, 114, 187, 0, 0, 0};
    tbl[4] = '{1'b1, 2'd3, 1, 115, 187, 3, 1, 5};
    tbl[5] = '{1'b1, 2'd2, 1, 115, 188, 2, 1, 5};
    tbl[6] = '{1'b1, 2'd1, 0, 115, 188, 2, 0, 0};
    tbl[7] = '{1'b0, 2'd0, 2, 114, 188, 1, 1, 5};
    tbl[8] = '{1'b1, 2'd0, 2, 113, 188, 1, 1, 6};
    tbl[9] = '{1'b1, 2'd2, 2, 113, 189, 2, 1, 5};

    do_reset();
    check("reset.posX", int'(posX), 116);
    check("reset.posY", int'(posY), 188);
    check("reset.cur_dir", int'(cur_dir), 1);
    check("reset.moving", int'(moving), 0);
    check("reset.step_done", int'(step_done), 0);
    check("reset.overrun", int'(overrun), 0);
    check("reset.query_entity", int'(query_entity), 1);
    check("reset.query_x", int'(query_x), 116);
    check("reset.query_y", int'(query_y), 188);
    check("reset.query_dir", int'(query_dir), 1);

    for (int i = 0; i < 10; i++) begin
      do_tick(tbl[i].rq, tbl[i].rd, tbl[i].mode, 1'b0, 2'b00, lat, nsd, nov);
      check($sformatf("vec%0d.posX", i), int'(posX), tbl[i].x);
      check($sformatf("vec%0d.posY", i), int'(posY), tbl[i].y);
      check($sformatf("vec%0d.cur_dir", i), int'(cur_dir), tbl[i].d);
      check($sformatf("vec%0d.moving", i), int'(moving), tbl[i].mov);
      check($sformatf("vec%0d.latency", i), lat, tbl[i].lat);
      check($sformatf("vec%0d.steps", i), nsd, (tbl[i].lat != 0) ? 1 : 0);
      check($sformatf("vec%0d.overrun", i), nov, 0);
    end

    // Request strobe lands while an earlier request is being accepted.
    do_reset();
    do_tick(1'b1, 2'd0, 1, 1'b1, 2'd3, lat, nsd, nov);
    check("coincide.accept_dir", int'(cur_dir), 0);
    check("coincide.accept_posY", int'(posY), 187);
    do_tick(1'b0, 2'd0, 1, 1'b0, 2'b00, lat, nsd, nov);
    check("coincide.kept_dir", int'(cur_dir), 3);
    check("coincide.kept_posX", int'(posX), 117);

    // Second tick while busy: dropped with a single overrun pulse.
    do_reset();
    allow_mode = 1;
    nsd = 0; nov = 0;
    @(negedge Clk); frame_clk = 1'b1;
    @(negedge Clk); frame_clk = 1'b0;
    @(negedge Clk); frame_clk = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge Clk);
      #1;
      if (step_done) nsd++;
      if (overrun) nov++;
      if (k == 2) frame_clk = 1'b0;
    end
    check("overrun.pulses", nov, 1);
    check("overrun.steps", nsd, 1);
    check("overrun.posX", int'(posX), 115);

    // Reset asserted mid-sequence, while the FSM is busy.
    @(negedge Clk); frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    #2;
    check("midreset.posX", int'(posX), 116);
    check("midreset.cur_dir", int'(cur_dir), 1);
    check("midreset.moving", int'(moving), 0);
    check("midreset.step_done", int'(step_done), 0);
    frame_clk = 1'b0;
    do_reset();
    run_model("postreset", 1'b0, 0, 1);

    // Randomised ticks against the model.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      run_model($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 9) < 3) ? 1 : 3);
    end

    // Left edge of the maze.
    guard = 0;
    while (mx != 0 && guard < 300) begin
      run_model("toleft", 1'b1, 1, 1);
      guard++;
    end
    check("toleft.reached", mx, 0);
    run_model("leftedge", 1'b1, 1, 1);
    check("leftedge.posX", int'(posX), WRAP ? 223 : 0);

    // Right edge of the maze.
    guard = 0;
    while (mx != 223 && guard < 300) begin
      run_model("toright", 1'b1, 3, 1);
      guard++;
    end
    check("toright.reached", mx, 223);
    run_model("rightedge", 1'b1, 3, 1);
    check("rightedge.posX", int'(posX), WRAP ? 0 : 223);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
